// File: rtl/alu32_pkg.sv
// Shared opcode encoding, shifter mode and width constants for the alu32 execute-stage ALU.
package alu32_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned SHAMT_W       = 5;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_SLL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_SRL = 4'd5,
    OP_SRA = 4'd6,
    OP_XOR = 4'd7,
    OP_ROR = 4'd8
  } op_e;

  typedef enum logic [1:0] {
    ShSll,
    ShSrl,
    ShSra,
    ShRor
  } shift_mode_e;

endpackage

// File: rtl/alu32_if.sv
// Operand/opcode inputs and registered result/flag outputs of alu32.
interface alu32_if #(
  parameter int unsigned WIDTH = alu32_pkg::DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       op;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             overflow;
  logic             zero;

  modport master (
    output a, b, op,
    input  result, carryout, overflow, zero
  );

  modport slave (
    input  a, b, op,
    output result, carryout, overflow, zero
  );

endinterface

// File: rtl/alu32_shifter.sv
// Combinational barrel shifter: logical left/right, arithmetic right and rotate right.
module alu32_shifter
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  input  shift_mode_e        mode,
  output logic [WIDTH-1:0]   result
);

  logic [WIDTH-1:0] rot;

  // Rotate right: output bit i takes input bit (i + shamt) mod WIDTH.
  always_comb begin
    rot = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      rot[i] = a[(i + int'(shamt)) % int'(WIDTH)];
    end
  end

  always_comb begin
    result = '0;
    case (mode)
      ShSll:   result = a << shamt;
      ShSrl:   result = a >> shamt;
      ShSra:   result = $signed(a) >>> shamt;
      ShRor:   result = rot;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu32.sv
// Registered 32-bit ALU: shared add/sub adder, barrel shifter, bitwise logic and flag register.
module alu32
  import alu32_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  alu32_if.slave bus
);

  logic [WIDTH-1:0] b_eff;
  logic             is_sub;
  logic [WIDTH:0]   sum;
  logic             add_ovf;
  logic [WIDTH-1:0] shift_res;
  shift_mode_e      shift_mode;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d, carry_q;
  logic             ovf_d, ovf_q;
  logic             zero_d, zero_q;

  // SUB reuses the adder as a + ~b + 1; carry-out then means "no borrow".
  assign is_sub  = (bus.op == OP_SUB);
  assign b_eff   = is_sub ? ~bus.b : bus.b;
  assign sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  assign add_ovf = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);

  always_comb begin
    shift_mode = ShSll;
    case (bus.op)
      OP_SRL:  shift_mode = ShSrl;
      OP_SRA:  shift_mode = ShSra;
      OP_ROR:  shift_mode = ShRor;
      default: shift_mode = ShSll;
    endcase
  end

  alu32_shifter #(
    .WIDTH(WIDTH)
  ) u_shifter (
    .a     (bus.a),
    .shamt (bus.b[SHAMT_W-1:0]),
    .mode  (shift_mode),
    .result(shift_res)
  );

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (bus.op)
      OP_ADD, OP_SUB: begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
        ovf_d    = add_ovf;
      end
      OP_SLL, OP_SRL, OP_SRA, OP_ROR: result_d = shift_res;
      OP_AND:  result_d = bus.a & bus.b;
      OP_OR:   result_d = bus.a | bus.b;
      OP_XOR:  result_d = bus.a ^ bus.b;
      default: result_d = '0;
    endcase
    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.result   = result_q;
  assign bus.carryout = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;

endmodule

// File: tb/tb_alu32.sv
// Directed-vector bench for alu32: table of hand-computed results plus reset/reserved-op sequences.
module tb_alu32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  alu32_if #(.WIDTH(32)) bus ();

  alu32 #(
    .WIDTH(32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] res, input logic c,
                           input logic v, input logic z);
    check({name, ".result"}, bus.result, res);
    check({name, ".carryout"}, {31'd0, bus.carryout}, {31'd0, c});
    check({name, ".overflow"}, {31'd0, bus.overflow}, {31'd0, v});
    check({name, ".zero"}, {31'd0, bus.zero}, {31'd0, z});
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bus.a  = a;
    bus.b  = b;
    bus.op = op;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            a             b             op     result        c     v     z
    vecs[0]  = '{32'h7FFFFFF1, 32'h00140656, 4'd0, 32'h80140647, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'h00145BC4, 32'h80000011, 4'd1, 32'h80145BB3, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h12345678, 32'h12345678, 4'd1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{32'h0001D991, 32'h00000004, 4'd2, 32'h001D9910, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{32'h00B942A7, 32'h00000005, 4'd5, 32'h0005CA15, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0012F091, 32'h000841C2, 4'd3, 32'h00004080, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h80000000, 32'h00000023, 4'd6, 32'hF0000000, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h80000000, 32'h00000001, 4'd8, 32'h40000000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h00000001, 4'd0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{32'hF0F00000, 32'h0000F0F0, 4'd4, 32'hF0F0F0F0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hAAAA5555, 32'hFFFF0000, 4'd7, 32'h55555555, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{32'h12345678, 32'h00000020, 4'd2, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{32'h12345678, 32'h00000004, 4'd8, 32'h81234567, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{32'h70000000, 32'h00000004, 4'd6, 32'h07000000, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{32'h00000001, 32'h00000001, 4'd15, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{32'h00000005, 32'h00000003, 4'd1, 32'h00000002, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{32'h00000003, 32'h00000005, 4'd1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{32'hDEADBEEF, 32'hFFFFFFE0, 4'd8, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{32'h80000000, 32'h0000001F, 4'd5, 32'h00000001, 1'b0, 1'b0, 1'b0};

    rst = 1'b1;
    drive(32'h0, 32'h0, 4'd0);
    #1;
    check_all("reset_state", 32'h0, 1'b0, 1'b0, 1'b1);

    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: a new vector is presented every cycle.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z);
    end

    // Non-zero result with flags set, then asynchronous reset mid-cycle.
    @(negedge clk);
    drive(32'h7FFFFFFF, 32'h00000001, 4'd0);
    @(posedge clk);
    #1;
    check_all("pre_reset", 32'h80000000, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check_all("reset_hold", 32'h0, 1'b0, 1'b0, 1'b1);

    // First post-reset edge computes from inputs present at that edge.
    @(negedge clk);
    rst = 1'b0;
    drive(32'h00000001, 32'h00000002, 4'd0);
    @(posedge clk);
    #1;
    check_all("post_reset_add", 32'h00000003, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    drive(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd12);
    @(posedge clk);
    #1;
    check_all("reserved_op12", 32'h0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
